// File: rtl/cpm_topk_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpm_topk_pkg
// Description : Shared types and default sizes for the top-K sort controller.
//               Holds the controller FSM state encoding and the default
//               widths used by cpm_topk_ctrl and cpm_topk_omux.
// Revision    : 1.0 - initial release
// ============================================================================
package cpm_topk_pkg;

    localparam int DEF_DATA_DW = 8;   // candidate value width
    localparam int DEF_INFO_DW = 8;   // candidate index width
    localparam int DEF_SORT_DW = 32;  // number of sorter slots
    localparam int DEF_LEN_AW  = 8;   // candidate count width

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLR   = 3'd1,
        ST_FEED  = 3'd2,
        ST_WAIT  = 3'd3,
        ST_DRAIN = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

endpackage
`default_nettype wire

// File: rtl/cpm_topk_omux.sv
`default_nettype none
// ============================================================================
// Module      : cpm_topk_omux
// Description : SORT_DW:1 selector picking one sorter slot (value + index)
//               by the drain counter.
// Ports       : sel_i  - slot select
//               dat_i  - all slot values, slot n at [n*DATA_DW +: DATA_DW]
//               inf_i  - all slot indices, slot n at [n*INFO_DW +: INFO_DW]
//               dat_o  - selected slot value
//               inf_o  - selected slot index
// Revision    : 1.0 - initial release
// ============================================================================
module cpm_topk_omux
    import cpm_topk_pkg::*;
#(
    parameter int SORT_DW = DEF_SORT_DW,
    parameter int DATA_DW = DEF_DATA_DW,
    parameter int INFO_DW = DEF_INFO_DW,
    parameter int SEL_W   = 5
) (
    input  logic [SEL_W-1:0]           sel_i,
    input  logic [SORT_DW*DATA_DW-1:0] dat_i,
    input  logic [SORT_DW*INFO_DW-1:0] inf_i,
    output logic [DATA_DW-1:0]         dat_o,
    output logic [INFO_DW-1:0]         inf_o
);

    logic [DATA_DW-1:0] w_dat_slot [SORT_DW];
    logic [INFO_DW-1:0] w_inf_slot [SORT_DW];

    generate
        for (genvar gi = 0; gi < SORT_DW; gi++) begin : g_slot
            assign w_dat_slot[gi] = dat_i[gi*DATA_DW +: DATA_DW];
            assign w_inf_slot[gi] = inf_i[gi*INFO_DW +: INFO_DW];
        end
    endgenerate

    assign dat_o = w_dat_slot[sel_i];
    assign inf_o = w_inf_slot[sel_i];

endmodule
`default_nettype wire

// File: rtl/cpm_topk_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : cpm_topk_ctrl
// Description : Job controller around an external top-K sorter. Accepts a job
//               (candidate count + K), clears the sorter, streams candidates
//               into it tagged with their index, waits for the sorted result
//               and drains the first K slots on an output stream.
// Ports       : clk/rst_n          - clock, async active-high reset
//               CFG_*              - job request handshake, length and K
//               ABORT              - single-cycle job cancel
//               IN_*               - candidate input stream
//               SORT_*             - sorter clear and candidate feed
//               TOPK_*             - sorter result slots
//               OUT_*              - result output stream
//               BUSY/DONE          - status and end-of-job pulse
// Revision    : 1.0 - initial release
// ============================================================================
module cpm_topk_ctrl
    import cpm_topk_pkg::*;
#(
    parameter int DATA_DW = DEF_DATA_DW,
    parameter int INFO_DW = DEF_INFO_DW,
    parameter int SORT_DW = DEF_SORT_DW,
    parameter int LEN_AW  = DEF_LEN_AW
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       CFG_VLD,
    output logic                       CFG_RDY,
    input  logic [LEN_AW-1:0]          CFG_LEN,
    input  logic [$clog2(SORT_DW):0]   CFG_K,
    input  logic                       ABORT,
    input  logic                       IN_VLD,
    output logic                       IN_RDY,
    input  logic [DATA_DW-1:0]         IN_DAT,
    output logic                       SORT_CLR,
    output logic                       SORT_DAT_VLD,
    output logic                       SORT_DAT_LST,
    output logic [DATA_DW-1:0]         SORT_DAT_DAT,
    output logic [INFO_DW-1:0]         SORT_DAT_INF,
    input  logic                       TOPK_DAT_VLD,
    input  logic [SORT_DW*DATA_DW-1:0] TOPK_DAT_DAT,
    input  logic [SORT_DW*INFO_DW-1:0] TOPK_DAT_INF,
    output logic                       OUT_VLD,
    input  logic                       OUT_RDY,
    output logic                       OUT_LST,
    output logic [DATA_DW-1:0]         OUT_DAT,
    output logic [INFO_DW-1:0]         OUT_INF,
    output logic                       BUSY,
    output logic                       DONE
);

    localparam int KW    = $clog2(SORT_DW) + 1;
    localparam int SEL_W = (SORT_DW > 1) ? $clog2(SORT_DW) : 1;

    state_t              state_q, state_d;
    logic [LEN_AW-1:0]   len_q,   len_d;
    logic [KW-1:0]       k_q,     k_d;
    logic [LEN_AW-1:0]   feed_q,  feed_d;
    logic [SEL_W-1:0]    drain_q, drain_d;

    logic [KW-1:0]       w_k_clamp;
    logic                w_feed_last;
    logic                w_drain_last;

    // K of zero still emits one result; K beyond the sorter depth saturates.
    always_comb begin
        w_k_clamp = CFG_K;
        if (CFG_K == '0) begin
            w_k_clamp = KW'(1);
        end else if (CFG_K > KW'(SORT_DW)) begin
            w_k_clamp = KW'(SORT_DW);
        end
    end

    assign w_feed_last  = (feed_q == len_q - LEN_AW'(1));
    assign w_drain_last = (KW'(drain_q) == k_q - KW'(1));

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q <= ST_IDLE;
            len_q   <= '0;
            k_q     <= '0;
            feed_q  <= '0;
            drain_q <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            k_q     <= k_d;
            feed_q  <= feed_d;
            drain_q <= drain_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        len_d        = len_q;
        k_d          = k_q;
        feed_d       = feed_q;
        drain_d      = drain_q;
        CFG_RDY      = 1'b0;
        IN_RDY       = 1'b0;
        SORT_CLR     = 1'b0;
        SORT_DAT_VLD = 1'b0;
        SORT_DAT_LST = 1'b0;
        OUT_VLD      = 1'b0;
        OUT_LST      = 1'b0;
        DONE         = 1'b0;

        case (state_q)
            ST_IDLE: begin
                CFG_RDY = 1'b1;
                // A simultaneous ABORT blocks the request from being taken.
                if (CFG_VLD && !ABORT) begin
                    len_d   = CFG_LEN;
                    k_d     = w_k_clamp;
                    state_d = ST_CLR;
                end
            end
            ST_CLR: begin
                SORT_CLR = 1'b1;
                feed_d   = '0;
                drain_d  = '0;
                state_d  = (len_q == '0) ? ST_DONE : ST_FEED;
            end
            ST_FEED: begin
                IN_RDY       = 1'b1;
                SORT_DAT_VLD = IN_VLD;
                SORT_DAT_LST = w_feed_last;
                if (IN_VLD) begin
                    feed_d = feed_q + LEN_AW'(1);
                    if (w_feed_last) begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (TOPK_DAT_VLD) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                OUT_VLD = 1'b1;
                OUT_LST = w_drain_last;
                if (OUT_RDY) begin
                    drain_d = drain_q + SEL_W'(1);
                    if (w_drain_last) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                DONE     = 1'b1;
                SORT_CLR = 1'b1;
                state_d  = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Cancel overrides everything outside IDLE: clear the sorter, kill
        // all traffic this cycle and skip the DONE pulse.
        if (ABORT && (state_q != ST_IDLE)) begin
            state_d      = ST_IDLE;
            feed_d       = '0;
            drain_d      = '0;
            SORT_CLR     = 1'b1;
            IN_RDY       = 1'b0;
            SORT_DAT_VLD = 1'b0;
            SORT_DAT_LST = 1'b0;
            OUT_VLD      = 1'b0;
            OUT_LST      = 1'b0;
            DONE         = 1'b0;
        end
    end

    assign BUSY         = (state_q != ST_IDLE);
    assign SORT_DAT_DAT = IN_DAT;
    assign SORT_DAT_INF = INFO_DW'(feed_q);

    cpm_topk_omux #(
        .SORT_DW (SORT_DW),
        .DATA_DW (DATA_DW),
        .INFO_DW (INFO_DW),
        .SEL_W   (SEL_W)
    ) u_omux (
        .sel_i (drain_q),
        .dat_i (TOPK_DAT_DAT),
        .inf_i (TOPK_DAT_INF),
        .dat_o (OUT_DAT),
        .inf_o (OUT_INF)
    );

endmodule
`default_nettype wire

// File: tb/tb_cpm_topk_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_cpm_topk_ctrl
// Description : Directed self-checking bench for cpm_topk_ctrl. The sorter is
//               replaced by fixed slot contents so every drained value is
//               known in advance.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cpm_topk_ctrl;

    localparam int DATA_DW = 8;
    localparam int INFO_DW = 8;
    localparam int SORT_DW = 32;
    localparam int LEN_AW  = 8;

    logic                       clk;
    logic                       rst_n;
    logic                       CFG_VLD;
    logic                       CFG_RDY;
    logic [LEN_AW-1:0]          CFG_LEN;
    logic [$clog2(SORT_DW):0]   CFG_K;
    logic                       ABORT;
    logic                       IN_VLD;
    logic                       IN_RDY;
    logic [DATA_DW-1:0]         IN_DAT;
    logic                       SORT_CLR;
    logic                       SORT_DAT_VLD;
    logic                       SORT_DAT_LST;
    logic [DATA_DW-1:0]         SORT_DAT_DAT;
    logic [INFO_DW-1:0]         SORT_DAT_INF;
    logic                       TOPK_DAT_VLD;
    logic [SORT_DW*DATA_DW-1:0] TOPK_DAT_DAT;
    logic [SORT_DW*INFO_DW-1:0] TOPK_DAT_INF;
    logic                       OUT_VLD;
    logic                       OUT_RDY;
    logic                       OUT_LST;
    logic [DATA_DW-1:0]         OUT_DAT;
    logic [INFO_DW-1:0]         OUT_INF;
    logic                       BUSY;
    logic                       DONE;

    int n_cmp = 0;
    int n_err = 0;

    cpm_topk_ctrl #(
        .DATA_DW (DATA_DW),
        .INFO_DW (INFO_DW),
        .SORT_DW (SORT_DW),
        .LEN_AW  (LEN_AW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .CFG_VLD      (CFG_VLD),
        .CFG_RDY      (CFG_RDY),
        .CFG_LEN      (CFG_LEN),
        .CFG_K        (CFG_K),
        .ABORT        (ABORT),
        .IN_VLD       (IN_VLD),
        .IN_RDY       (IN_RDY),
        .IN_DAT       (IN_DAT),
        .SORT_CLR     (SORT_CLR),
        .SORT_DAT_VLD (SORT_DAT_VLD),
        .SORT_DAT_LST (SORT_DAT_LST),
        .SORT_DAT_DAT (SORT_DAT_DAT),
        .SORT_DAT_INF (SORT_DAT_INF),
        .TOPK_DAT_VLD (TOPK_DAT_VLD),
        .TOPK_DAT_DAT (TOPK_DAT_DAT),
        .TOPK_DAT_INF (TOPK_DAT_INF),
        .OUT_VLD      (OUT_VLD),
        .OUT_RDY      (OUT_RDY),
        .OUT_LST      (OUT_LST),
        .OUT_DAT      (OUT_DAT),
        .OUT_INF      (OUT_INF),
        .BUSY         (BUSY),
        .DONE         (DONE)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Fixed sorter slot contents: value 7*n+3, index 0xA0+n.
    function automatic logic [DATA_DW-1:0] slot_dat(input int n);
        return DATA_DW'(n * 7 + 3);
    endfunction
    function automatic logic [INFO_DW-1:0] slot_inf(input int n);
        return INFO_DW'(8'hA0 + n);
    endfunction

    // Start a job: request on one negedge, drop it on the next (state is CLR).
    task automatic start_job(input int len, input int k);
        @(negedge clk);
        CFG_VLD = 1'b1;
        CFG_LEN = LEN_AW'(len);
        CFG_K   = ($clog2(SORT_DW)+1)'(k);
        @(negedge clk);
        CFG_VLD = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        n_cmp++;
        if ({CFG_RDY, BUSY, DONE, SORT_CLR, SORT_DAT_VLD, IN_RDY, OUT_VLD, OUT_LST} !== 8'b1000_0000) begin
            n_err++;
            $display("FAIL reset_outputs: got %b want 10000000",
                     {CFG_RDY, BUSY, DONE, SORT_CLR, SORT_DAT_VLD, IN_RDY, OUT_VLD, OUT_LST});
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({CFG_RDY, BUSY, DONE} !== 3'b100) begin
            n_err++;
            $display("FAIL post_reset_idle: got %b want 100", {CFG_RDY, BUSY, DONE});
        end
    endtask

    // Full job: back-to-back feed of len beats, then drain of kexp results.
    task automatic test_job(input int len, input int kcfg, input int kexp, input int base);
        logic [DATA_DW-1:0] d;
        @(negedge clk);
        CFG_VLD = 1'b1;
        CFG_LEN = LEN_AW'(len);
        CFG_K   = ($clog2(SORT_DW)+1)'(kcfg);
        #1;
        n_cmp++;
        if (CFG_RDY !== 1'b1) begin
            n_err++;
            $display("FAIL job_cfg_rdy: got %b want 1", CFG_RDY);
        end
        @(negedge clk);
        CFG_VLD = 1'b0;
        #1;
        n_cmp++;
        if ({SORT_CLR, BUSY, CFG_RDY, IN_RDY} !== 4'b1100) begin
            n_err++;
            $display("FAIL job_clr: got %b want 1100", {SORT_CLR, BUSY, CFG_RDY, IN_RDY});
        end
        for (int i = 0; i < len; i++) begin
            @(negedge clk);
            d      = DATA_DW'(base + i * 13);
            IN_VLD = 1'b1;
            IN_DAT = d;
            #1;
            n_cmp++;
            if ({IN_RDY, SORT_DAT_VLD, SORT_DAT_LST, SORT_DAT_DAT, SORT_DAT_INF} !==
                {1'b1, 1'b1, (i == len - 1), d, INFO_DW'(i)}) begin
                n_err++;
                $display("FAIL job_feed beat %0d: got rdy=%b vld=%b lst=%b dat=%0d inf=%0d want rdy=1 vld=1 lst=%b dat=%0d inf=%0d",
                         i, IN_RDY, SORT_DAT_VLD, SORT_DAT_LST, SORT_DAT_DAT, SORT_DAT_INF,
                         (i == len - 1), d, i);
            end
        end
        @(negedge clk);
        IN_VLD       = 1'b0;
        TOPK_DAT_VLD = 1'b1;
        #1;
        n_cmp++;
        if ({IN_RDY, SORT_DAT_VLD, OUT_VLD, BUSY} !== 4'b0001) begin
            n_err++;
            $display("FAIL job_wait: got %b want 0001", {IN_RDY, SORT_DAT_VLD, OUT_VLD, BUSY});
        end
        for (int j = 0; j < kexp; j++) begin
            @(negedge clk);
            TOPK_DAT_VLD = 1'b0;
            OUT_RDY      = 1'b1;
            #1;
            n_cmp++;
            if ({OUT_VLD, OUT_LST, OUT_DAT, OUT_INF} !==
                {1'b1, (j == kexp - 1), slot_dat(j), slot_inf(j)}) begin
                n_err++;
                $display("FAIL job_drain beat %0d: got vld=%b lst=%b dat=%0d inf=%0h want vld=1 lst=%b dat=%0d inf=%0h",
                         j, OUT_VLD, OUT_LST, OUT_DAT, OUT_INF,
                         (j == kexp - 1), slot_dat(j), slot_inf(j));
            end
        end
        @(negedge clk);
        OUT_RDY = 1'b0;
        #1;
        n_cmp++;
        if ({DONE, SORT_CLR, OUT_VLD} !== 3'b110) begin
            n_err++;
            $display("FAIL job_done: got %b want 110", {DONE, SORT_CLR, OUT_VLD});
        end
        @(negedge clk);
        #1;
        n_cmp++;
        if ({DONE, CFG_RDY, BUSY} !== 3'b010) begin
            n_err++;
            $display("FAIL job_idle: got %b want 010", {DONE, CFG_RDY, BUSY});
        end
    endtask

    task automatic test_toggle_feed();
        int beats = 0;
        start_job(4, 2);
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            IN_VLD = ((c % 2) == 0);
            IN_DAT = DATA_DW'(c + 1);
            #1;
            n_cmp++;
            if (SORT_DAT_VLD !== ((c % 2) == 0)) begin
                n_err++;
                $display("FAIL toggle_vld cycle %0d: got %b want %b", c, SORT_DAT_VLD, ((c % 2) == 0));
            end
            if (SORT_DAT_VLD === 1'b1) begin
                n_cmp++;
                if ({SORT_DAT_INF, SORT_DAT_LST} !== {INFO_DW'(beats), (beats == 3)}) begin
                    n_err++;
                    $display("FAIL toggle_idx cycle %0d: got inf=%0d lst=%b want inf=%0d lst=%b",
                             c, SORT_DAT_INF, SORT_DAT_LST, beats, (beats == 3));
                end
                beats++;
            end
        end
        IN_VLD = 1'b0;
        n_cmp++;
        if (beats != 4) begin
            n_err++;
            $display("FAIL toggle_beats: got %0d want 4", beats);
        end
        @(negedge clk);
        TOPK_DAT_VLD = 1'b1;
        for (int j = 0; j < 2; j++) begin
            @(negedge clk);
            TOPK_DAT_VLD = 1'b0;
            OUT_RDY      = 1'b1;
            #1;
            n_cmp++;
            if ({OUT_VLD, OUT_LST, OUT_DAT} !== {1'b1, (j == 1), slot_dat(j)}) begin
                n_err++;
                $display("FAIL toggle_drain beat %0d: got vld=%b lst=%b dat=%0d want vld=1 lst=%b dat=%0d",
                         j, OUT_VLD, OUT_LST, OUT_DAT, (j == 1), slot_dat(j));
            end
        end
        @(negedge clk);
        OUT_RDY = 1'b0;
        #1;
        n_cmp++;
        if (DONE !== 1'b1) begin
            n_err++;
            $display("FAIL toggle_done: got %b want 1", DONE);
        end
    endtask

    task automatic test_stall();
        start_job(2, 3);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            IN_VLD = 1'b1;
            IN_DAT = DATA_DW'(50 + i);
        end
        @(negedge clk);
        IN_VLD       = 1'b0;
        TOPK_DAT_VLD = 1'b1;
        @(negedge clk);
        TOPK_DAT_VLD = 1'b0;
        OUT_RDY      = 1'b1;
        @(negedge clk);
        OUT_RDY = 1'b0;
        for (int s = 0; s < 3; s++) begin
            #1;
            n_cmp++;
            if ({OUT_VLD, OUT_LST, OUT_DAT, OUT_INF} !== {1'b1, 1'b0, slot_dat(1), slot_inf(1)}) begin
                n_err++;
                $display("FAIL stall_hold cycle %0d: got vld=%b lst=%b dat=%0d inf=%0h want vld=1 lst=0 dat=%0d inf=%0h",
                         s, OUT_VLD, OUT_LST, OUT_DAT, OUT_INF, slot_dat(1), slot_inf(1));
            end
            @(negedge clk);
        end
        OUT_RDY = 1'b1;
        #1;
        n_cmp++;
        if ({OUT_VLD, OUT_DAT} !== {1'b1, slot_dat(1)}) begin
            n_err++;
            $display("FAIL stall_release: got vld=%b dat=%0d want vld=1 dat=%0d", OUT_VLD, OUT_DAT, slot_dat(1));
        end
        @(negedge clk);
        #1;
        n_cmp++;
        if ({OUT_VLD, OUT_LST, OUT_DAT} !== {1'b1, 1'b1, slot_dat(2)}) begin
            n_err++;
            $display("FAIL stall_last: got vld=%b lst=%b dat=%0d want vld=1 lst=1 dat=%0d",
                     OUT_VLD, OUT_LST, OUT_DAT, slot_dat(2));
        end
        @(negedge clk);
        OUT_RDY = 1'b0;
        #1;
        n_cmp++;
        if (DONE !== 1'b1) begin
            n_err++;
            $display("FAIL stall_done: got %b want 1", DONE);
        end
    endtask

    task automatic test_len_zero();
        start_job(0, 3);
        #1;
        n_cmp++;
        if ({SORT_CLR, IN_RDY} !== 2'b10) begin
            n_err++;
            $display("FAIL len0_clr: got %b want 10", {SORT_CLR, IN_RDY});
        end
        @(negedge clk);
        #1;
        n_cmp++;
        if ({DONE, SORT_CLR, SORT_DAT_VLD, OUT_VLD} !== 4'b1100) begin
            n_err++;
            $display("FAIL len0_done: got %b want 1100", {DONE, SORT_CLR, SORT_DAT_VLD, OUT_VLD});
        end
        @(negedge clk);
        #1;
        n_cmp++;
        if ({CFG_RDY, DONE} !== 2'b10) begin
            n_err++;
            $display("FAIL len0_idle: got %b want 10", {CFG_RDY, DONE});
        end
    endtask

    task automatic test_abort();
        start_job(4, 2);
        @(negedge clk);
        IN_VLD = 1'b1;
        IN_DAT = 8'd11;
        @(negedge clk);
        IN_DAT = 8'd22;
        ABORT  = 1'b1;
        #1;
        n_cmp++;
        if ({SORT_CLR, SORT_DAT_VLD, OUT_VLD, DONE} !== 4'b1000) begin
            n_err++;
            $display("FAIL abort_cycle: got %b want 1000", {SORT_CLR, SORT_DAT_VLD, OUT_VLD, DONE});
        end
        @(negedge clk);
        ABORT  = 1'b0;
        IN_VLD = 1'b0;
        #1;
        n_cmp++;
        if ({CFG_RDY, BUSY, DONE, SORT_CLR} !== 4'b1000) begin
            n_err++;
            $display("FAIL abort_idle: got %b want 1000", {CFG_RDY, BUSY, DONE, SORT_CLR});
        end
        test_job(3, 2, 2, 90);
    endtask

    task automatic test_reset_in_drain();
        start_job(1, 2);
        @(negedge clk);
        IN_VLD = 1'b1;
        IN_DAT = 8'd77;
        @(negedge clk);
        IN_VLD       = 1'b0;
        TOPK_DAT_VLD = 1'b1;
        @(negedge clk);
        TOPK_DAT_VLD = 1'b0;
        OUT_RDY      = 1'b0;
        #1;
        n_cmp++;
        if (OUT_VLD !== 1'b1) begin
            n_err++;
            $display("FAIL rst_drain_pre: got %b want 1", OUT_VLD);
        end
        #1;
        rst_n = 1'b1;
        #1;
        n_cmp++;
        if ({CFG_RDY, BUSY, DONE, SORT_CLR, SORT_DAT_VLD, IN_RDY, OUT_VLD, OUT_LST} !== 8'b1000_0000) begin
            n_err++;
            $display("FAIL rst_drain_async: got %b want 10000000",
                     {CFG_RDY, BUSY, DONE, SORT_CLR, SORT_DAT_VLD, IN_RDY, OUT_VLD, OUT_LST});
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({CFG_RDY, BUSY, DONE, OUT_VLD} !== 4'b1000) begin
            n_err++;
            $display("FAIL rst_drain_release: got %b want 1000", {CFG_RDY, BUSY, DONE, OUT_VLD});
        end
        test_job(2, 1, 1, 5);
    endtask

    initial begin
        rst_n        = 1'b1;
        CFG_VLD      = 1'b0;
        CFG_LEN      = '0;
        CFG_K        = '0;
        ABORT        = 1'b0;
        IN_VLD       = 1'b0;
        IN_DAT       = '0;
        TOPK_DAT_VLD = 1'b0;
        OUT_RDY      = 1'b0;
        for (int n = 0; n < SORT_DW; n++) begin
            TOPK_DAT_DAT[n*DATA_DW +: DATA_DW] = slot_dat(n);
            TOPK_DAT_INF[n*INFO_DW +: INFO_DW] = slot_inf(n);
        end

        test_reset();
        test_job(5, 3, 3, 10);      // basic job, values 10,23,36,49,62
        test_toggle_feed();
        test_stall();
        test_len_zero();
        test_job(1, 0, 1, 200);     // K=0 emits one result
        test_job(2, 40, 32, 100);   // K above depth saturates at 32
        test_abort();
        test_reset_in_drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cpm_topk_ctrl.md
CPM_TOPK_CTRL -- requirements
Module: cpm_topk_ctrl

Interface
REQ-001 SHALL have parameter DATA_DW, default 8, candidate data width.
REQ-002 SHALL have parameter INFO_DW, default 8, candidate info (index) width; INFO_DW >= LEN_AW.
REQ-003 SHALL have parameter SORT_DW, default 32, number of sorter slots.
REQ-004 SHALL have parameter LEN_AW, default 8, candidate-count width.
REQ-005 SHALL have ports, clock and reset first:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous, active-high reset (asserted = 1).
- CFG_VLD  in  1  job request.
- CFG_RDY  out  1  high only in IDLE.
- CFG_LEN  in  LEN_AW  candidates per job.
- CFG_K  in  clog2(SORT_DW)+1  results to emit.
- ABORT  in  1  single-cycle job cancel.
- IN_VLD  in  1  candidate valid.
- IN_RDY  out  1  candidate ready.
- IN_DAT  in  DATA_DW  candidate value.
- SORT_CLR  out  1  sorter clear.
- SORT_DAT_VLD  out  1  sorter input valid.
- SORT_DAT_LST  out  1  last candidate.
- SORT_DAT_DAT  out  DATA_DW  candidate to sorter.
- SORT_DAT_INF  out  INFO_DW  candidate index.
- TOPK_DAT_VLD  in  1  sorter result valid.
- TOPK_DAT_DAT  in  SORT_DW x DATA_DW  sorter slots.
- TOPK_DAT_INF  in  SORT_DW x INFO_DW  sorter slot info.
- OUT_VLD  out  1  result valid.
- OUT_RDY  in  1  result ready.
- OUT_LST  out  1  last result of job.
- OUT_DAT  out  DATA_DW  result value.
- OUT_INF  out  INFO_DW  result index.
- BUSY  out  1  state != IDLE.
- DONE  out  1  one-cycle pulse at job end.

Function
REQ-006 SHALL implement FSM IDLE -> CLR -> FEED -> WAIT -> DRAIN -> DONE -> IDLE.
REQ-007 IDLE: CFG_RDY=1; CFG_VLD latches len=CFG_LEN and k=min(max(CFG_K,1),SORT_DW); next state CLR.
REQ-008 CLR: SORT_CLR=1 for exactly one cycle; next FEED, or DONE if len=0 (no sorter traffic, no OUT beats).
REQ-009 FEED: IN_RDY=1; SORT_DAT_VLD=IN_VLD; SORT_DAT_DAT=IN_DAT; SORT_DAT_INF=feed counter zero-extended; combinational pass-through, zero latency.
REQ-010 Feed counter SHALL start at 0 and increment per IN_VLD&&IN_RDY; SORT_DAT_LST=1 when counter=len-1; that beat moves FSM to WAIT.
REQ-011 WAIT: IN_RDY=0, SORT_DAT_VLD=0; move to DRAIN on first cycle TOPK_DAT_VLD=1 (one cycle after last beat).
REQ-012 DRAIN: OUT_VLD=1; OUT_DAT/OUT_INF=TOPK_DAT_DAT/INF[drain counter]; counter starts 0, increments per OUT_VLD&&OUT_RDY.
REQ-013 OUT_LST=1 when drain counter=k-1; that handshake moves FSM to DONE.
REQ-014 OUT_DAT/OUT_INF SHALL hold stable while OUT_VLD=1 and OUT_RDY=0.
REQ-015 DONE: DONE=1 one cycle, SORT_CLR=1 same cycle; next IDLE.
REQ-016 ABORT in any non-IDLE state SHALL force SORT_CLR=1 that cycle, suppress SORT_DAT_VLD/OUT_VLD, return to IDLE next cycle; no DONE; ABORT in IDLE ignored and takes priority over CFG_VLD.
REQ-017 CFG_VLD outside IDLE SHALL be ignored (CFG_RDY=0).
REQ-018 Outputs in non-listed states SHALL be 0; SORT_DAT_DAT/INF and OUT_DAT/INF may be don't-care when corresponding VLD=0.

Reset
REQ-019 rst_n=1 SHALL asynchronously force state IDLE, counters 0, len/k 0.
REQ-020 During/after reset: CFG_RDY=1, BUSY=0, DONE=0, SORT_CLR=0, SORT_DAT_VLD=0, IN_RDY=0, OUT_VLD=0, OUT_LST=0.
REQ-021 Reset mid-job SHALL drop the job without DONE; the sorter is reset by the same rst_n.

Structure
REQ-022 Package cpm_topk_pkg SHALL hold FSM state enum and default DATA_DW/INFO_DW/SORT_DW/LEN_AW constants.
REQ-023 One sub-module cpm_topk_omux (SORT_DW:1 mux of DAT/INF by drain counter) SHALL be used; everything else inline.

Verification
REQ-024 CFG_LEN=5, CFG_K=3, IN_DAT 10,40,20,50,30 back-to-back -> LST on 5th beat, INF 0..4, three OUT beats with sorter slots 0..2, OUT_LST on 3rd, DONE once.
REQ-025 CFG_LEN=4, K=2, IN_VLD toggling every other cycle -> exactly 4 SORT_DAT_VLD beats, counter advances only on handshake.
REQ-026 DRAIN with OUT_RDY low 3 cycles -> OUT_VLD held, OUT_DAT/INF unchanged, no drain counter advance.
REQ-027 CFG_LEN=0 -> CLR, DONE pulse, no SORT_DAT_VLD, no OUT_VLD; CFG_K=0 -> 1 beat; CFG_K=40 -> 32 beats.
REQ-028 ABORT on 2nd FEED beat -> SORT_CLR=1 that cycle, IDLE next cycle, no DONE; new job then completes normally.
REQ-029 rst_n pulsed during DRAIN -> all outputs to reset values immediately, CFG_RDY=1 after release.
